br_resolve: RTL and testbench



---
 rtl/br_resolve_pkg.sv | 28 ++
 rtl/br_resolve_if.sv | 37 +++
 rtl/br_resolve_sync_fifo.sv | 54 +++++
 rtl/br_resolve.sv | 102 ++++++++++
 tb/tb_br_resolve.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/br_resolve_pkg.sv
// Shared types and constants for the branch resolution controller.
package br_resolve_pkg;

    localparam int unsigned RV32_PC_WIDTH = 32;

    typedef enum logic [1:0] {
        BRRES_IDLE     = 2'd0,
        BRRES_FLUSH    = 2'd1,
        BRRES_REDIRECT = 2'd2
    } brres_state_t;

    typedef struct packed {
        logic [RV32_PC_WIDTH-1:0] pc;
        logic [RV32_PC_WIDTH-1:0] target;
        logic                     taken;
    } upd_rec_t;

    localparam int unsigned BRRES_UPD_WIDTH = RV32_PC_WIDTH * 2 + 1;

    function automatic logic [RV32_PC_WIDTH-1:0] brres_next_pc(
        input logic                     taken,
        input logic [RV32_PC_WIDTH-1:0] pc,
        input logic [RV32_PC_WIDTH-1:0] target
    );
        return taken ? target : pc + RV32_PC_WIDTH'(4);
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Finish, redirect and predictor-update signals of the branch resolution controller.
interface br_resolve_if;
    import br_resolve_pkg::*;

    logic                     i_exfin;
    logic [RV32_PC_WIDTH-1:0] i_exfin_pc;
    logic [RV32_PC_WIDTH-1:0] i_exfin_jmpaddr;
    logic                     i_exfin_jmpcond;
    logic                     i_exfin_prsucc;
    logic                     i_exfin_prmiss;
    logic                     o_accessable;
    logic                     o_flush;
    logic                     o_redirect_vld;
    logic [RV32_PC_WIDTH-1:0] o_redirect_pc;
    logic                     i_redirect_rdy;
    logic                     o_upd_vld;
    logic [RV32_PC_WIDTH-1:0] o_upd_pc;
    logic [RV32_PC_WIDTH-1:0] o_upd_target;
    logic                     o_upd_taken;
    logic                     i_upd_rdy;
    logic                     o_ovf;

    modport slave (
        input  i_exfin, i_exfin_pc, i_exfin_jmpaddr, i_exfin_jmpcond,
               i_exfin_prsucc, i_exfin_prmiss, i_redirect_rdy, i_upd_rdy,
        output o_accessable, o_flush, o_redirect_vld, o_redirect_pc,
               o_upd_vld, o_upd_pc, o_upd_target, o_upd_taken, o_ovf
    );

    modport master (
        output i_exfin, i_exfin_pc, i_exfin_jmpaddr, i_exfin_jmpcond,
               i_exfin_prsucc, i_exfin_prmiss, i_redirect_rdy, i_upd_rdy,
        input  o_accessable, o_flush, o_redirect_vld, o_redirect_pc,
               o_upd_vld, o_upd_pc, o_upd_target, o_upd_taken, o_ovf
    );

endinterface

// File: rtl/br_resolve_sync_fifo.sv
// Synchronous FIFO; a pop frees the slot for a same-cycle push when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; empty/count gate everything visible downstream.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution controller: misprediction flush/redirect FSM plus predictor update queue.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int unsigned UPD_DEPTH    = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    br_resolve_if.slave  bus
);
    localparam int unsigned CW = $clog2(UPD_DEPTH) + 1;
    localparam int unsigned FW = $clog2(FLUSH_CYCLES) + 1;

    brres_state_t             r_state, w_state_nxt;
    logic [FW-1:0]            r_flush_cnt, w_flush_cnt_nxt;
    logic [RV32_PC_WIDTH-1:0] r_redirect_pc, w_redirect_pc_nxt;
    logic                     r_ovf;

    logic                       w_push_req;
    logic                       w_pop_req;
    logic                       w_miss;
    logic                       w_full;
    logic                       w_empty;
    logic [CW-1:0]              w_count;
    logic [BRRES_UPD_WIDTH-1:0] w_dout;
    upd_rec_t                   w_head;
    upd_rec_t                   w_rec_in;

    // prsucc is one-hot with prmiss on legal input; qualifying with it changes nothing there.
    assign w_miss    = bus.i_exfin_prmiss && !bus.i_exfin_prsucc;
    assign w_rec_in  = '{pc: bus.i_exfin_pc, target: bus.i_exfin_jmpaddr, taken: bus.i_exfin_jmpcond};
    assign w_pop_req = !w_empty && bus.i_upd_rdy;

    always_comb begin
        w_state_nxt       = r_state;
        w_flush_cnt_nxt   = r_flush_cnt;
        w_redirect_pc_nxt = r_redirect_pc;
        w_push_req        = 1'b0;
        case (r_state)
            BRRES_IDLE: begin
                w_push_req = bus.i_exfin;
                if (bus.i_exfin && w_miss) begin
                    w_state_nxt       = BRRES_FLUSH;
                    w_flush_cnt_nxt   = FW'(FLUSH_CYCLES - 1);
                    w_redirect_pc_nxt = brres_next_pc(bus.i_exfin_jmpcond,
                                                      bus.i_exfin_pc, bus.i_exfin_jmpaddr);
                end
            end
            BRRES_FLUSH: begin
                if (r_flush_cnt == '0) w_state_nxt = BRRES_REDIRECT;
                else                   w_flush_cnt_nxt = r_flush_cnt - 1'b1;
            end
            BRRES_REDIRECT: begin
                if (bus.i_redirect_rdy) w_state_nxt = BRRES_IDLE;
            end
            default: w_state_nxt = BRRES_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BRRES_IDLE;
            r_flush_cnt   <= '0;
            r_redirect_pc <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            if (w_push_req && w_full && !w_pop_req) r_ovf <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (BRRES_UPD_WIDTH),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_din   (w_rec_in),
        .i_pop   (w_pop_req),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head = upd_rec_t'(w_dout);

    assign bus.o_flush        = (r_state == BRRES_FLUSH);
    assign bus.o_redirect_vld = (r_state == BRRES_REDIRECT);
    assign bus.o_redirect_pc  = r_redirect_pc;
    assign bus.o_accessable   = (r_state == BRRES_IDLE) && (w_count <= CW'(UPD_DEPTH - 2));
    assign bus.o_upd_vld      = !w_empty;
    assign bus.o_upd_pc       = w_empty ? '0   : w_head.pc;
    assign bus.o_upd_target   = w_empty ? '0   : w_head.target;
    assign bus.o_upd_taken    = w_empty ? 1'b0 : w_head.taken;
    assign bus.o_ovf          = r_ovf;

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve with a timeline/queue reference model checked every cycle.
module tb_br_resolve;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FC    = 2;

    logic clk;
    logic rst;
    br_resolve_if bus ();

    br_resolve #(
        .UPD_DEPTH    (DEPTH),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: records in a queue, misprediction handling as a cycle timeline.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } rec_t;

    rec_t        q[$];
    bit          chk_en = 0;
    bit          m_ovf, m_pending;
    int          m_cyc, m_flush_until, m_redir_from;
    logic [31:0] m_rpc;
    bit          was_full, popped, hs;
    rec_t        nr;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 0; m_pending = 0; m_rpc = '0; m_cyc = 0;
            chk_en = 1;
        end else begin
            was_full = (q.size() == DEPTH);
            popped   = (q.size() > 0) && bus.i_upd_rdy;
            hs       = m_pending && (m_cyc >= m_redir_from) && bus.i_redirect_rdy;
            if (popped) void'(q.pop_front());
            if (!m_pending && bus.i_exfin) begin
                nr.pc = bus.i_exfin_pc; nr.tgt = bus.i_exfin_jmpaddr; nr.tk = bus.i_exfin_jmpcond;
                if (was_full && !popped) m_ovf = 1;
                else q.push_back(nr);
                if (bus.i_exfin_prmiss) begin
                    m_pending     = 1;
                    m_flush_until = m_cyc + FC;
                    m_redir_from  = m_cyc + FC + 1;
                    m_rpc = bus.i_exfin_jmpcond ? bus.i_exfin_jmpaddr : bus.i_exfin_pc + 32'd4;
                end
            end else if (hs) begin
                m_pending = 0;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("flush",        {31'b0, bus.o_flush},        {31'b0, m_pending && (m_cyc <= m_flush_until)});
            chk("redirect_vld", {31'b0, bus.o_redirect_vld}, {31'b0, m_pending && (m_cyc >= m_redir_from)});
            chk("redirect_pc",  bus.o_redirect_pc,           m_rpc);
            chk("accessable",   {31'b0, bus.o_accessable},   {31'b0, !m_pending && (q.size() <= DEPTH - 2)});
            chk("upd_vld",      {31'b0, bus.o_upd_vld},      {31'b0, q.size() > 0});
            chk("upd_pc",       bus.o_upd_pc,                (q.size() > 0) ? q[0].pc : 32'h0);
            chk("upd_target",   bus.o_upd_target,            (q.size() > 0) ? q[0].tgt : 32'h0);
            chk("upd_taken",    {31'b0, bus.o_upd_taken},    {31'b0, (q.size() > 0) ? q[0].tk : 1'b0});
            chk("ovf",          {31'b0, bus.o_ovf},          {31'b0, m_ovf});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exfin(input logic [31:0] pc, input logic [31:0] tgt, input logic cond, input logic miss);
        bus.i_exfin = 1'b1; bus.i_exfin_pc = pc; bus.i_exfin_jmpaddr = tgt;
        bus.i_exfin_jmpcond = cond; bus.i_exfin_prmiss = miss; bus.i_exfin_prsucc = !miss;
        cycle();
        bus.i_exfin = 1'b0; bus.i_exfin_prmiss = 1'b0; bus.i_exfin_prsucc = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_exfin = 1'b0; bus.i_exfin_pc = '0; bus.i_exfin_jmpaddr = '0;
        bus.i_exfin_jmpcond = 1'b0; bus.i_exfin_prsucc = 1'b0; bus.i_exfin_prmiss = 1'b0;
        bus.i_redirect_rdy = 1'b1; bus.i_upd_rdy = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_accessable", {31'b0, bus.o_accessable}, 32'd1);
        chk("rst_flush",      {31'b0, bus.o_flush},      32'd0);
        chk("rst_upd_vld",    {31'b0, bus.o_upd_vld},    32'd0);
        chk("rst_redir_pc",   bus.o_redirect_pc,         32'h0);
        cycle();

        // Correct prediction
        exfin(32'h100, 32'h200, 1'b1, 1'b0);
        chk("t1_upd_vld",   {31'b0, bus.o_upd_vld},   32'd1);
        chk("t1_upd_pc",    bus.o_upd_pc,             32'h100);
        chk("t1_upd_tgt",   bus.o_upd_target,         32'h200);
        chk("t1_upd_taken", {31'b0, bus.o_upd_taken}, 32'd1);
        chk("t1_flush",     {31'b0, bus.o_flush},     32'd0);
        cycle();
        chk("t1_drained",   {31'b0, bus.o_upd_vld},   32'd0);

        // Not-taken miss with redirect back-pressure
        bus.i_redirect_rdy = 1'b0;
        exfin(32'h400, 32'h480, 1'b0, 1'b1);
        chk("t2_flush1",  {31'b0, bus.o_flush},      32'd1);
        chk("t2_acc",     {31'b0, bus.o_accessable}, 32'd0);
        cycle();
        chk("t2_flush2",  {31'b0, bus.o_flush},      32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_flush_off", {31'b0, bus.o_flush},        32'd0);
            chk("t2_rvld",      {31'b0, bus.o_redirect_vld}, 32'd1);
            chk("t2_rpc",       bus.o_redirect_pc,           32'h404);
        end
        bus.i_redirect_rdy = 1'b1;
        cycle();
        chk("t2_idle_vld", {31'b0, bus.o_redirect_vld}, 32'd0);
        chk("t2_idle_acc", {31'b0, bus.o_accessable},   32'd1);

        // Taken miss with wrong-path traffic during flush
        bus.i_upd_rdy = 1'b0;
        exfin(32'h800, 32'h1000, 1'b1, 1'b1);
        exfin(32'h900, 32'h904, 1'b0, 1'b1);
        exfin(32'hA00, 32'hB00, 1'b1, 1'b0);
        chk("t3_rvld", {31'b0, bus.o_redirect_vld}, 32'd1);
        chk("t3_rpc",  bus.o_redirect_pc,           32'h1000);
        cycle();
        chk("t3_head", bus.o_upd_pc,            32'h800);
        chk("t3_acc",  {31'b0, bus.o_accessable}, 32'd1);
        bus.i_upd_rdy = 1'b1;
        cycle();
        chk("t3_one_rec", {31'b0, bus.o_upd_vld}, 32'd0);
        chk("t3_no_ovf",  {31'b0, bus.o_ovf},     32'd0);

        // Back-pressure, overflow, push+pop when full
        bus.i_upd_rdy = 1'b0;
        exfin(32'h10, 32'h14, 1'b0, 1'b0);
        chk("t4_acc1", {31'b0, bus.o_accessable}, 32'd1);
        exfin(32'h20, 32'h24, 1'b0, 1'b0);
        chk("t4_acc2", {31'b0, bus.o_accessable}, 32'd1);
        exfin(32'h30, 32'h34, 1'b0, 1'b0);
        chk("t4_acc3", {31'b0, bus.o_accessable}, 32'd0);
        exfin(32'h40, 32'h44, 1'b0, 1'b0);
        chk("t4_full_ovf", {31'b0, bus.o_ovf}, 32'd0);
        exfin(32'h50, 32'h54, 1'b0, 1'b0);
        chk("t4_ovf", {31'b0, bus.o_ovf}, 32'd1);
        bus.i_upd_rdy = 1'b1;
        exfin(32'h60, 32'h64, 1'b1, 1'b0);
        bus.i_upd_rdy = 1'b0;
        chk("t4_head2", bus.o_upd_pc,              32'h20);
        chk("t4_acc4",  {31'b0, bus.o_accessable}, 32'd0);
        bus.i_upd_rdy = 1'b1;
        cycle(); cycle(); cycle();
        chk("t4_head6",  bus.o_upd_pc,            32'h60);
        chk("t4_taken6", {31'b0, bus.o_upd_taken}, 32'd1);
        cycle();
        chk("t4_empty",  {31'b0, bus.o_upd_vld},   32'd0);

        // PC wrap-around on not-taken miss
        exfin(32'hFFFF_FFFC, 32'h0000_0040, 1'b0, 1'b1);
        cycle(); cycle();
        chk("t5_rvld", {31'b0, bus.o_redirect_vld}, 32'd1);
        chk("t5_rpc",  bus.o_redirect_pc,           32'h0);
        cycle();
        chk("t5_idle", {31'b0, bus.o_accessable},   32'd1);

        // Reset while in REDIRECT with three queued records
        bus.i_upd_rdy = 1'b0; bus.i_redirect_rdy = 1'b0;
        exfin(32'h110, 32'h114, 1'b0, 1'b0);
        exfin(32'h120, 32'h124, 1'b0, 1'b0);
        exfin(32'h130, 32'h3000, 1'b1, 1'b1);
        cycle(); cycle();
        chk("t6_pre_rvld", {31'b0, bus.o_redirect_vld}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_upd_vld", {31'b0, bus.o_upd_vld},      32'd0);
        chk("t6_rvld",    {31'b0, bus.o_redirect_vld}, 32'd0);
        chk("t6_ovf",     {31'b0, bus.o_ovf},          32'd0);
        chk("t6_acc",     {31'b0, bus.o_accessable},   32'd1);
        chk("t6_rpc",     bus.o_redirect_pc,           32'h0);
        bus.i_redirect_rdy = 1'b1;
        exfin(32'h140, 32'h144, 1'b1, 1'b0);
        chk("t6_post_push", bus.o_upd_pc, 32'h140);
        bus.i_upd_rdy = 1'b1;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
